// File: rtl/img_pkg.sv
`default_nettype none
// ============================================================================
// Module      : img_pkg
// Description : Definitions shared by the switch command generator and the
//               image converter. Holds the mode encodings, the command record
//               and the sequence-number helper.
// Revision    : 1.0 - initial release
// ============================================================================
package img_pkg;

    // Mode encodings. Each board switch owns one bit of the mode vector.
    localparam logic [3:0] MODE_IDLE = 4'b0000;
    localparam logic [3:0] MODE_SW0  = 4'b0001;
    localparam logic [3:0] MODE_SW1  = 4'b0010;
    localparam logic [3:0] MODE_SW2  = 4'b0100;
    localparam logic [3:0] MODE_SW3  = 4'b1000;

    // One mode command as it travels to the converter.
    typedef struct packed {
        logic [3:0] mode;
        logic [3:0] seq;
    } cmd_t;

    // Sequence numbers are modulo 16; the 4-bit add wraps 15 -> 0.
    function automatic logic [3:0] seq_next(input logic [3:0] s);
        return s + 4'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/swt_cmd_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : swt_cmd_gen_if
// Description : Mode-command channel from the switch front end (master,
//               producer) to the image converter (slave, consumer).
//               cmd_valid/cmd_ready : handshake, transfer when both high
//               cmd_mode            : debounced switch vector
//               cmd_seq             : command sequence number
//               cmd_drop            : one-cycle pulse, pending command lost
// Revision    : 1.0 - initial release
// ============================================================================
interface swt_cmd_gen_if;
    import img_pkg::*;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_mode;
    logic [3:0] cmd_seq;
    logic       cmd_drop;

    modport master (
        output cmd_valid,
        output cmd_mode,
        output cmd_seq,
        output cmd_drop,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_mode,
        input  cmd_seq,
        input  cmd_drop,
        output cmd_ready
    );

endinterface
`default_nettype wire

// File: rtl/sync_debounce.sv
`default_nettype none
// ============================================================================
// Module      : sync_debounce
// Description : Synchronises an asynchronous vector and debounces it as a
//               whole. A new value is accepted once the synchronised vector
//               has stayed identical for DEBOUNCE_CYCLES consecutive samples
//               after the change was first seen.
//   clk          : system clock, rising edge
//   rst          : asynchronous reset, active high
//   i_swt        : raw asynchronous input vector
//   o_stable     : current debounced vector
//   o_event      : one-cycle pulse, o_stable takes o_event_mode this edge
//   o_event_mode : value being accepted (valid with o_event)
// Revision    : 1.0 - initial release
// ============================================================================
module sync_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int WIDTH           = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [WIDTH-1:0] i_swt,
    output logic      [WIDTH-1:0] o_stable,
    output logic                  o_event,
    output logic      [WIDTH-1:0] o_event_mode
);

    localparam int                c_cnt_w   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0]   r_sync [SYNC_STAGES];
    logic [WIDTH-1:0]   w_swt_s;
    logic [WIDTH-1:0]   r_cand;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_stable;

    // Metastability chain; stage 0 is the only flop that sees the raw input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= i_swt;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_swt_s = r_sync[SYNC_STAGES-1];

    // The event is combinational so that the output stage can capture the
    // command on the same edge that updates r_stable.
    assign o_event      = (w_swt_s == r_cand) && (r_cnt == c_cnt_max) && (r_cand != r_stable);
    assign o_event_mode = r_cand;
    assign o_stable     = r_stable;

    // Any change restarts the count; the counter saturates so a settled value
    // that matches r_stable simply idles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cand   <= '0;
            r_cnt    <= '0;
            r_stable <= '0;
        end else if (w_swt_s != r_cand) begin
            r_cand <= w_swt_s;
            r_cnt  <= '0;
        end else if (r_cnt != c_cnt_max) begin
            r_cnt <= r_cnt + 1'b1;
        end else if (r_cand != r_stable) begin
            r_stable <= r_cand;
        end
    end

endmodule
`default_nettype wire

// File: rtl/swt_cmd_gen.sv
`default_nettype none
// ============================================================================
// Module      : swt_cmd_gen
// Description : Switch front end for the image converter. Debounces the four
//               board switches and issues a sequence-numbered mode command for
//               every settled change, through an output register backed by a
//               one-deep skid slot.
//   clk        : system clock, rising edge
//   rstb       : asynchronous reset, active high
//   swt        : raw switch inputs (asynchronous)
//   cmd        : command channel (master side of swt_cmd_gen_if)
//   stable_swt : current debounced switch vector
//   busy       : output register or skid slot occupied
// Revision    : 1.0 - initial release
// ============================================================================
module swt_cmd_gen
    import img_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  wire logic       clk,
    input  wire logic       rstb,
    input  wire logic [3:0] swt,
    swt_cmd_gen_if.master   cmd,
    output logic      [3:0] stable_swt,
    output logic            busy
);

    logic       w_event;
    logic [3:0] w_event_mode;
    cmd_t       w_event_cmd;
    logic       w_fire;
    logic       w_load;

    logic [3:0] r_seq;
    cmd_t       r_out;
    logic       r_out_valid;
    cmd_t       r_skid;
    logic       r_skid_valid;
    logic       r_drop;

    sync_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .WIDTH           (4)
    ) u_sync_debounce (
        .clk          (clk),
        .rst          (rstb),
        .i_swt        (swt),
        .o_stable     (stable_swt),
        .o_event      (w_event),
        .o_event_mode (w_event_mode)
    );

    // A command carries the post-increment sequence number.
    assign w_event_cmd = {w_event_mode, seq_next(r_seq)};

    assign w_fire = r_out_valid && cmd.cmd_ready;
    assign w_load = !r_out_valid || w_fire;

    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            r_seq        <= '0;
            r_out        <= '{mode: MODE_IDLE, seq: 4'd0};
            r_out_valid  <= 1'b0;
            r_skid       <= '{mode: MODE_IDLE, seq: 4'd0};
            r_skid_valid <= 1'b0;
            r_drop       <= 1'b0;
        end else begin
            r_drop <= 1'b0;
            if (w_event) begin
                r_seq <= w_event_cmd.seq;
            end

            if (w_load) begin
                // Older skid content always wins the free output register;
                // a coincident event then takes its place in the skid.
                if (r_skid_valid) begin
                    r_out        <= r_skid;
                    r_out_valid  <= 1'b1;
                    r_skid_valid <= w_event;
                    if (w_event) begin
                        r_skid <= w_event_cmd;
                    end
                end else begin
                    r_out_valid <= w_event;
                    if (w_event) begin
                        r_out <= w_event_cmd;
                    end
                end
            end else if (w_event) begin
                // Output stalled: the newest command replaces any waiting one.
                r_skid       <= w_event_cmd;
                r_skid_valid <= 1'b1;
                r_drop       <= r_skid_valid;
            end
        end
    end

    assign cmd.cmd_valid = r_out_valid;
    assign cmd.cmd_mode  = r_out.mode;
    assign cmd.cmd_seq   = r_out.seq;
    assign cmd.cmd_drop  = r_drop;
    assign busy          = r_out_valid | r_skid_valid;

endmodule
`default_nettype wire

// File: doc/swt_cmd_gen.md
# swt_cmd_gen

Front-end block driving the image converter's mode input. Takes the four raw board switches, synchronises and debounces them as a vector, and turns every settled change into a mode command. Commands go to the converter over a valid/ready handshake, with one-deep skid buffering. The converter is the consumer end of this interface; this block is the producer.

## Interface
Parameters:
- SYNC_STAGES, 2, flip-flops in the metastability chain (≥2)
- DEBOUNCE_CYCLES, 16, consecutive identical synchronised samples required before a change is accepted (≥2)

Ports:
- clk  in  1  single system clock, rising edge
- rstb  in  1  reset, asynchronous, active-high (asserted = 1)
- swt  in  4  raw switch inputs, asynchronous to clk
- cmd_valid  out  1  command available
- cmd_ready  in  1  consumer accepts command when high with cmd_valid
- cmd_mode  out  4  debounced switch vector carried by the command
- cmd_seq  out  4  command sequence number, wraps 15→0
- cmd_drop  out  1  one-cycle pulse: a pending command was overwritten
- stable_swt  out  4  current debounced switch vector
- busy  out  1  output or skid slot occupied

## Operation
- Sync chain: SYNC_STAGES flops on swt; last stage is swt_s.
- Debounce (whole vector), registers cand[3:0] and cnt (width clog2(DEBOUNCE_CYCLES)):
  - swt_s != cand: cand←swt_s, cnt←0.
  - else cnt != DEBOUNCE_CYCLES-1: cnt←cnt+1.
  - else cand != stable_swt: stable_swt←cand, raise internal event (one cycle) with mode=cand.
  - cnt saturates at DEBOUNCE_CYCLES-1; no event while cand == stable_swt.
- Sequence counter seq increments by 1 (mod 16) on every event; the event's command carries the post-increment value. The first command after reset has cmd_seq=1.
- Output stage: output register (cmd_valid, cmd_mode, cmd_seq) plus skid register (skid_valid, mode, seq). Handshake fires when cmd_valid && cmd_ready.
  - Output register loads from skid if skid_valid, otherwise from event, whenever it is empty or the handshake fires.
  - If skid supplies the output and an event occurs the same cycle, the event goes into skid.
  - Event while output is held (valid, no handshake): goes to skid if skid is empty. If skid is full, skid is overwritten with the new event and cmd_drop pulses for 1 cycle.
  - Output register contents never change while cmd_valid && !cmd_ready.
- busy = cmd_valid | skid_valid.
- Reset mid-operation clears everything immediately. Any in-flight command is lost without a cmd_drop pulse.

## Timing
- Reset values: cmd_valid=0, cmd_mode=0, cmd_seq=0, cmd_drop=0, stable_swt=0, busy=0. Internally cand=0, cnt=0, seq=0, skid_valid=0, and all sync flops=0.
- Latency: a swt change first sampled at edge 0 and held steady gives stable_swt and cmd_valid high after edge SYNC_STAGES+DEBOUNCE_CYCLES (18 with defaults), provided the output register is free.
- A glitch shorter than DEBOUNCE_CYCLES samples of swt_s produces no event. A change reverting to the current stable_swt before settling produces no event.
- Handshake with skid empty and a simultaneous event: the new command appears the next cycle, so cmd_valid stays high continuously.
- cmd_drop is registered and asserts in the cycle after the overwriting event.
- Throughput: at most one event per DEBOUNCE_CYCLES+1 cycles. With cmd_ready tied high, no command is ever dropped.

## Structure
- Shared package img_pkg: mode encoding constants (MODE_IDLE=4'b0000, and per-switch mode bits) and the cmd struct typedef {mode[3:0], seq[3:0]}. The converter imports the same package.
- Sub-module sync_debounce (parameters SYNC_STAGES, DEBOUNCE_CYCLES, WIDTH=4) implements the sync chain and the debounce logic. It outputs stable_swt and an event pulse. Top level contains seq, the output stage, and the skid buffer.

## Test plan
- Reset: hold rstb=1 for 100 ns, swt=4'b1111 → all outputs 0. After release with swt held, stable_swt=4'b1111, cmd_valid=1, cmd_mode=4'b1111, cmd_seq=1 exactly 18 cycles after the first sampling edge.
- Glitch: stable 4'b0001, pulse swt=4'b0011 for 10 cycles → no event, stable_swt stays 4'b0001, cmd_valid stays 0.
- Back-pressure: cmd_ready=0, apply 4'b0001, then 4'b0010, then 4'b0100, each held 40 cycles → output holds {0001,seq1} and skid holds {0010,seq2}. The third change overwrites skid with {0100,seq3} and cmd_drop pulses once. Then raise cmd_ready → {0001,1} then {0100,3} are delivered, then busy=0.
- Streaming: cmd_ready=1, apply sequence 0001,0010,0100,1000,1001,0110 every 125 cycles → six commands with seq 1..6 in order and no cmd_drop.
- Sequence wrap: 17 alternating changes with cmd_ready=1 → cmd_seq goes 15 then 0 then 1.
- Reset mid-operation: assert rstb while cmd_valid=1 and skid full → outputs reach reset values asynchronously, with no cmd_drop pulse.
